// File: rtl/elevator_sched.sv
// Elevator call scheduler: synchronised (optionally debounced) call switches,
// latched floor requests and a single-car SCAN controller with door timing.
// Optional feature macro: ELEVATOR_SCHED_DEBOUNCE_EN enables per-switch debounce.
module elevator_sched #(
    parameter int unsigned NFLOORS    = 4,
    parameter int unsigned TRAVEL_CYC = 50000000,
    parameter int unsigned DOOR_CYC   = 100000000,
    parameter int unsigned DB_CYC     = 500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NFLOORS-1:0] sw,
    output logic [NFLOORS-1:0] led_floor,
    output logic [NFLOORS-1:0] led_req,
    output logic               led_door,
    output logic               led_up,
    output logic               led_down
);

    localparam int unsigned CW   = (NFLOORS > 2) ? $clog2(NFLOORS) : 1;
    localparam int unsigned TMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DOOR} state_e;

    logic [NFLOORS-1:0] sync1_q, sync2_q, clean_c, prev_q, armed_q, press_c;
    logic [1:0]         valid_q;

    // Two-flop synchroniser, edge history and arming against switches held through reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            armed_q <= '0;
            valid_q <= '0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
            prev_q  <= clean_c;
            valid_q <= {valid_q[0], 1'b1};
            armed_q <= armed_q | ({NFLOORS{valid_q[1]}} & ~sync2_q & ~clean_c);
        end
    end

`ifdef ELEVATOR_SCHED_DEBOUNCE_EN
    localparam int unsigned DBW = $clog2(DB_CYC + 1);

    logic [NFLOORS-1:0] db_q;
    logic [DBW-1:0]     db_cnt_q [NFLOORS];

    // Per-bit debounce: flip the stable value after DB_CYC consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q <= '0;
            for (int i = 0; i < int'(NFLOORS); i++) db_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NFLOORS); i++) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (db_cnt_q[i] == DBW'(DB_CYC - 1)) begin
                        db_q[i]     <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign clean_c = db_q;
`else
    logic unused_db_c;
    assign unused_db_c = (DB_CYC != 32'd0);
    assign clean_c     = sync2_q;
`endif

    assign press_c = clean_c & ~prev_q & armed_q;

    function automatic logic any_above(input logic [NFLOORS-1:0] r, input logic [CW-1:0] c);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(NFLOORS); i++) if (CW'(i) > c) hit = hit | r[i];
        return hit;
    endfunction

    function automatic logic any_below(input logic [NFLOORS-1:0] r, input logic [CW-1:0] c);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(NFLOORS); i++) if (CW'(i) < c) hit = hit | r[i];
        return hit;
    endfunction

    state_e             state_q, state_d;
    logic               dir_q, dir_d;          // 1 = up
    logic [CW-1:0]      cur_q, cur_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [NFLOORS-1:0] req_q, req_d;
    logic [NFLOORS-1:0] led_floor_d;
    logic               led_door_d, led_up_d, led_down_d;
    logic               door_press_c;

    // State register, controller registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b1;
            cur_q     <= '0;
            timer_q   <= '0;
            req_q     <= '0;
            led_floor <= NFLOORS'(1);
            led_door  <= 1'b0;
            led_up    <= 1'b0;
            led_down  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            cur_q     <= cur_d;
            timer_q   <= timer_d;
            req_q     <= req_d;
            led_floor <= led_floor_d;
            led_door  <= led_door_d;
            led_up    <= led_up_d;
            led_down  <= led_down_d;
        end
    end

    // Next-state logic: SCAN scheduling, travel and door timing, request latching
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        cur_d        = cur_q;
        timer_d      = timer_q;
        req_d        = req_q | press_c;
        door_press_c = (state_q == S_DOOR) && press_c[cur_q];
        if (state_q == S_DOOR) req_d[cur_q] = req_q[cur_q];

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (req_q[cur_q]) begin
                    state_d = S_DOOR;
                end else if (dir_q && any_above(req_q, cur_q)) begin
                    state_d = S_UP;
                    dir_d   = 1'b1;
                end else if (any_below(req_q, cur_q)) begin
                    state_d = S_DOWN;
                    dir_d   = 1'b0;
                end else if (any_above(req_q, cur_q)) begin
                    state_d = S_UP;
                    dir_d   = 1'b1;
                end
            end
            S_UP: begin
                if (timer_q == TW'(TRAVEL_CYC - 1)) begin
                    timer_d = '0;
                    if (cur_q != CW'(NFLOORS - 1)) cur_d = cur_q + CW'(1);
                    if (req_q[cur_d])                  state_d = S_DOOR;
                    else if (!any_above(req_q, cur_d)) state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DOWN: begin
                if (timer_q == TW'(TRAVEL_CYC - 1)) begin
                    timer_d = '0;
                    if (cur_q != '0) cur_d = cur_q - CW'(1);
                    if (req_q[cur_d])                  state_d = S_DOOR;
                    else if (!any_below(req_q, cur_d)) state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DOOR: begin
                if (door_press_c) begin
                    timer_d = '0;
                end else if (timer_q == TW'(DOOR_CYC - 1)) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_DOOR) && (state_q != S_DOOR)) req_d[cur_d] = 1'b0;
    end

    // Output decode from next state, loaded into the output registers
    always_comb begin
        led_floor_d = NFLOORS'(1) << cur_d;
        led_door_d  = (state_d == S_DOOR);
        led_up_d    = (state_d == S_UP);
        led_down_d  = (state_d == S_DOWN);
    end

    assign led_req = req_q;

endmodule

// File: tb/tb_elevator_sched.sv
// Self-checking bench for elevator_sched (NFLOORS=4, TRAVEL_CYC=8, DOOR_CYC=4, DB_CYC=3).
module tb_elevator_sched;

    localparam int N    = 4;
    localparam int TRAV = 8;
    localparam int DOOR = 4;
    localparam int DB   = 3;
`ifdef ELEVATOR_SCHED_DEBOUNCE_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] sw  = '0;
    logic [N-1:0] led_floor, led_req;
    logic         led_door, led_up, led_down;

    elevator_sched #(.NFLOORS(N), .TRAVEL_CYC(TRAV), .DOOR_CYC(DOOR), .DB_CYC(DB)) dut (
        .clk(clk), .rst(rst), .sw(sw),
        .led_floor(led_floor), .led_req(led_req),
        .led_door(led_door), .led_up(led_up), .led_down(led_down)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 up, 2 down, 3 door; m_left counts cycles remaining
    int           m_mode, m_cur, m_left;
    bit           m_dirup;
    logic [N-1:0] m_req;
    logic [N-1:0] h1, h2, h3;   // switch samples at the previous three edges (1 = not a real low)
    bit           model_en;

    function automatic bit req_above(input logic [N-1:0] r, input int c);
        for (int j = c + 1; j < N; j++) if (r[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit req_below(input logic [N-1:0] r, input int c);
        for (int j = 0; j < c; j++) if (r[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cur = 0; m_left = 0; m_dirup = 1'b1; m_req = '0;
        h1 = '1; h2 = '1; h3 = '1;
    endtask

    task automatic model_step(input logic [N-1:0] s);
        logic [N-1:0] p, nreq;
        bit           entering;
        p  = h2 & ~h3;
        h3 = h2; h2 = h1; h1 = s;
        nreq = m_req | p;
        entering = 1'b0;
        if (m_mode == 3 && p[m_cur]) nreq[m_cur] = m_req[m_cur];
        case (m_mode)
            0: begin
                if (m_req[m_cur]) begin
                    m_mode = 3; m_left = DOOR; entering = 1'b1;
                end else if (m_dirup && req_above(m_req, m_cur)) begin
                    m_mode = 1; m_left = TRAV;
                end else if (req_below(m_req, m_cur)) begin
                    m_mode = 2; m_left = TRAV; m_dirup = 1'b0;
                end else if (req_above(m_req, m_cur)) begin
                    m_mode = 1; m_left = TRAV; m_dirup = 1'b1;
                end
            end
            1, 2: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_mode == 1 && m_cur < N - 1) m_cur++;
                    if (m_mode == 2 && m_cur > 0)     m_cur--;
                    if (m_req[m_cur]) begin
                        m_mode = 3; m_left = DOOR; entering = 1'b1;
                    end else if ((m_mode == 1) ? req_above(m_req, m_cur) : req_below(m_req, m_cur)) begin
                        m_left = TRAV;
                    end else begin
                        m_mode = 0;
                    end
                end
            end
            default: begin
                if (p[m_cur]) m_left = DOOR;
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            end
        endcase
        if (entering) nreq[m_cur] = 1'b0;
        m_req = nreq;
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else     model_step(sw);
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst && model_en) begin
            check_eq("m_floor", 32'(led_floor), 32'(1) << m_cur);
            check_eq("m_req",   32'(led_req),   32'(m_req));
            check_eq("m_door",  32'(led_door),  32'(m_mode == 3));
            check_eq("m_up",    32'(led_up),    32'(m_mode == 1));
            check_eq("m_down",  32'(led_down),  32'(m_mode == 2));
        end
    end

    // Activity counters and door-opening log
    int door_cnt, up_cnt, down_cnt;
    int door_log[$];
    bit prev_door;

    always @(negedge clk) begin
        if (rst) prev_door = 1'b0;
        else begin
            door_cnt += int'(led_door);
            up_cnt   += int'(led_up);
            down_cnt += int'(led_down);
            if (led_door && !prev_door)
                for (int j = 0; j < N; j++) if (led_floor[j]) door_log.push_back(j);
            prev_door = led_door;
        end
    end

    task automatic clr_cnt();
        door_cnt = 0; up_cnt = 0; down_cnt = 0;
        door_log.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Asynchronous reset asserted off the clock edge; outputs must drop immediately
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_eq({tag, "_floor"}, 32'(led_floor), 32'h1);
        check_eq({tag, "_req"},   32'(led_req),   32'h0);
        check_eq({tag, "_door"},  32'(led_door),  32'h0);
        check_eq({tag, "_up"},    32'(led_up),    32'h0);
        check_eq({tag, "_down"},  32'(led_down),  32'h0);
        tick(2);
        rst = 1'b0;
        tick(3);
        clr_cnt();
    endtask

    task automatic pulse(input logic [N-1:0] m);
        sw = m;
        tick(HOLD);
        sw = '0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int k;
        k = 0;
        tick(4);
        while (!(led_req == '0 && !led_door && !led_up && !led_down) && k < maxc) begin
            tick(1);
            k++;
        end
        check_eq({tag, "_timeout"}, 32'(k < maxc), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
`ifdef ELEVATOR_SCHED_DEBOUNCE_EN
        model_en = 1'b0;
`else
        model_en = 1'b1;
`endif
        model_reset();
        clr_cnt();
        tick(3);

        // Reset values
        do_reset("rst0");

        // Single call above: travel 0->2, door, back to idle
        pulse(4'b0100);
        wait_done("go2", 200);
        check_eq("go2_up",    32'(up_cnt),    32'd16);
        check_eq("go2_door",  32'(door_cnt),  32'd4);
        check_eq("go2_down",  32'(down_cnt),  32'd0);
        check_eq("go2_floor", 32'(led_floor), 32'b0100);

        // Call at the current floor: door only
        do_reset("rst1");
        pulse(4'b0001);
        wait_done("here", 100);
        check_eq("here_door", 32'(door_cnt), 32'd4);
        check_eq("here_move", 32'(up_cnt + down_cnt), 32'd0);

        // SCAN order: at floor 2 heading up, calls at 0 and 3 together
        do_reset("rst2");
        pulse(4'b0100);
        wait_done("scan_pre", 200);
        clr_cnt();
        pulse(4'b1001);
        wait_done("scan", 300);
        check_eq("scan_nstops", 32'(door_log.size()), 32'd2);
        if (door_log.size() == 2) begin
            check_eq("scan_first",  32'(door_log[0]), 32'd3);
            check_eq("scan_second", 32'(door_log[1]), 32'd0);
        end
        check_eq("scan_up",    32'(up_cnt),    32'd8);
        check_eq("scan_down",  32'(down_cnt),  32'd24);
        check_eq("scan_floor", 32'(led_floor), 32'b0001);

        // Reset mid-travel between floors 1 and 2 with requests pending
        do_reset("rst3");
        pulse(4'b1000);
        pulse(4'b0001);
        k = 0;
        while (led_floor != 4'b0010 && k < 100) begin tick(1); k++; end
        check_eq("mid_reach1", 32'(k < 100), 32'h1);
        tick(3);
        check_eq("mid_pre_up",  32'(led_up),        32'h1);
        check_eq("mid_pre_req", 32'(led_req != '0), 32'h1);
        do_reset("mid_rst");
        tick(20);
        check_eq("mid_lost_req", 32'(led_req),   32'h0);
        check_eq("mid_floor",    32'(led_floor), 32'h1);

        // Switch held high through reset release is not a press
        @(negedge clk);
        sw = 4'b0010;
        do_reset("held_rst");
        tick(30);
        check_eq("held_req", 32'(led_req), 32'h0);
        check_eq("held_up",  32'(led_up),  32'h0);
        sw = '0;
        tick(8);
        pulse(4'b0010);
        wait_done("held_rel", 200);
        check_eq("held_rel_up",    32'(up_cnt),    32'd8);
        check_eq("held_rel_door",  32'(door_cnt),  32'd4);
        check_eq("held_rel_floor", 32'(led_floor), 32'b0010);

`ifdef ELEVATOR_SCHED_DEBOUNCE_EN
        // Debounce: 2-cycle glitch rejected, 3-cycle stable high accepted
        do_reset("db_rst");
        sw = 4'b0010; tick(2); sw = '0;
        tick(15);
        check_eq("db_glitch_req", 32'(led_req), 32'h0);
        check_eq("db_glitch_up",  32'(led_up),  32'h0);
        sw = 4'b0010; tick(3); sw = '0;
        k = 0;
        while (led_req != 4'b0010 && k < 20) begin tick(1); k++; end
        check_eq("db_stable_req", 32'(led_req), 32'b0010);
        wait_done("db_done", 200);
`else
        // Randomised calls with occasional asynchronous resets
        do_reset("rnd_rst");
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) sw[b] = ($urandom_range(15) == 0);
            if ($urandom_range(999) == 0) do_reset("rnd_async");
            else tick(1);
        end
        sw = '0;
        wait_done("rnd_drain", 1000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
